stopwatch_controller: RTL and testbench

STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/stopwatch_time_counter.sv | 67 ++++++
 rtl/stopwatch_controller.sv | 103 ++++++++++
 tb/tb_stopwatch_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch controller.
// The lap/freeze feature is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    FULL    = 2'd3
  } state_t;

  localparam int HOUR_W = 4;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int MS_W   = 10;

  localparam logic [MS_W-1:0]   MS_MAX   = 10'd999;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_time_counter.sv
// Millisecond prescaler plus cascaded ms/s/min/h live counters.
// Saturates at 9:59:59.999; ms_tick flags the cycle a millisecond is due.
module stopwatch_time_counter import stopwatch_pkg::*; #(
  parameter int MS_DIV = 25000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              clear,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic [MS_W-1:0]   milliseconds,
  output logic              ms_tick,
  output logic              at_max
);

  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(MS_DIV - 1);

  logic [PW-1:0]     presc_q;
  logic [MS_W-1:0]   ms_q;
  logic [SEC_W-1:0]  sec_q;
  logic [MIN_W-1:0]  min_q;
  logic [HOUR_W-1:0] hour_q;

  assign ms_tick = advance && (presc_q == PRESC_LAST);
  assign at_max  = (hour_q == HOUR_MAX) && (min_q == MIN_MAX) &&
                   (sec_q == SEC_MAX) && (ms_q == MS_MAX);

  // All carries resolve in one edge; at the ceiling the tick is swallowed.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      presc_q <= '0;
      ms_q    <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
    end else if (advance) begin
      presc_q <= ms_tick ? '0 : presc_q + 1'b1;
      if (ms_tick && !at_max) begin
        if (ms_q == MS_MAX) begin
          ms_q <= '0;
          if (sec_q == SEC_MAX) begin
            sec_q <= '0;
            if (min_q == MIN_MAX) begin
              min_q  <= '0;
              hour_q <= hour_q + 1'b1;
            end else begin
              min_q <= min_q + 1'b1;
            end
          end else begin
            sec_q <= sec_q + 1'b1;
          end
        end else begin
          ms_q <= ms_q + 1'b1;
        end
      end
    end
  end

  assign hours        = hour_q;
  assign minutes      = min_q;
  assign seconds      = sec_q;
  assign milliseconds = ms_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch FSM with frame-synchronous display registers.
// Lap freeze is compiled in only when STOPWATCH_LAP_EN is defined.
module stopwatch_controller import stopwatch_pkg::*; #(
  parameter int CLK_HZ = 25000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_stop,
  input  logic              clear,
  input  logic              lap,
  input  logic              frame_start,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic [MS_W-1:0]   milliseconds,
  output logic              running,
  output logic              overflow,
  output logic              display_frozen
);

  localparam int MS_DIV = CLK_HZ / 1000;

  state_t state, state_next;

  logic [HOUR_W-1:0] live_hours;
  logic [MIN_W-1:0]  live_minutes;
  logic [SEC_W-1:0]  live_seconds;
  logic [MS_W-1:0]   live_ms;
  logic              ms_tick;
  logic              at_max;

  stopwatch_time_counter #(.MS_DIV(MS_DIV)) u_time (
    .clk          (clk),
    .reset        (reset),
    .advance      (state == RUNNING),
    .clear        (clear),
    .hours        (live_hours),
    .minutes      (live_minutes),
    .seconds      (live_seconds),
    .milliseconds (live_ms),
    .ms_tick      (ms_tick),
    .at_max       (at_max)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Reaching the ceiling wins over a simultaneous pause request.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_stop) state_next = RUNNING;
        RUNNING: begin
          if (ms_tick && at_max) state_next = FULL;
          else if (start_stop)   state_next = PAUSED;
        end
        PAUSED:  if (start_stop) state_next = RUNNING;
        default: state_next = state;
      endcase
    end
  end

  assign running  = (state == RUNNING);
  assign overflow = (state == FULL);

`ifdef STOPWATCH_LAP_EN
  logic frozen_q;

  always_ff @(posedge clk) begin
    if (reset || clear)
      frozen_q <= 1'b0;
    else if (lap && (state == RUNNING || state == PAUSED))
      frozen_q <= ~frozen_q;
  end

  assign display_frozen = frozen_q;
`else
  logic unused_lap;
  assign unused_lap     = lap;
  assign display_frozen = 1'b0;
`endif

  // Nonblocking load means a frame on a carry edge captures pre-increment time.
  always_ff @(posedge clk) begin
    if (reset) begin
      hours        <= '0;
      minutes      <= '0;
      seconds      <= '0;
      milliseconds <= '0;
    end else if (frame_start && !display_frozen) begin
      hours        <= live_hours;
      minutes      <= live_minutes;
      seconds      <= live_seconds;
      milliseconds <= live_ms;
    end
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller (CLK_HZ=4000, 4 clocks per ms).
// Honours STOPWATCH_LAP_EN the same way as the design build.
module tb_stopwatch_controller;

  localparam int CLK_HZ = 4000;
  localparam int MS_DIV = CLK_HZ / 1000;
  localparam int MAX_MS = 9*3600000 + 59*60000 + 59*1000 + 999;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic       frame_start = 1'b0;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [9:0] milliseconds;
  logic       running;
  logic       overflow;
  logic       display_frozen;

  int n_asserts = 0;
  int n_fail    = 0;

  // Model: 0 idle, 1 running, 2 paused, 3 full; time kept as total milliseconds.
  int m_state = 0;
  int m_total = 0;
  int m_sub   = 0;
  int m_disp  = 0;
  bit m_frozen = 1'b0;

  stopwatch_controller #(.CLK_HZ(CLK_HZ)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_stop     (start_stop),
    .clear          (clear),
    .lap            (lap),
    .frame_start    (frame_start),
    .hours          (hours),
    .minutes        (minutes),
    .seconds        (seconds),
    .milliseconds   (milliseconds),
    .running        (running),
    .overflow       (overflow),
    .display_frozen (display_frozen)
  );

  always #5 clk = ~clk;

  task automatic modelStep(input bit rst, input bit ss, input bit clr,
                           input bit lp, input bit fs);
    int old_total = m_total;
    int old_state = m_state;
    bit old_frozen = m_frozen;
    if (rst) begin
      m_state = 0; m_total = 0; m_sub = 0; m_disp = 0; m_frozen = 1'b0;
      return;
    end
    if (fs && !old_frozen) m_disp = old_total;
    if (clr) begin
      m_state = 0; m_total = 0; m_sub = 0; m_frozen = 1'b0;
      return;
    end
    if (old_state == 1) begin
      if (m_sub == MS_DIV - 1) begin
        m_sub = 0;
        if (m_total == MAX_MS) m_state = 3;
        else m_total = m_total + 1;
      end else begin
        m_sub = m_sub + 1;
      end
    end
    if (ss && m_state == old_state) begin
      case (old_state)
        0: m_state = 1;
        1: m_state = 2;
        2: m_state = 1;
        default: m_state = old_state;
      endcase
    end
`ifdef STOPWATCH_LAP_EN
    if (lp && (old_state == 1 || old_state == 2)) m_frozen = !m_frozen;
`else
    if (lp) m_frozen = 1'b0;
`endif
  endtask

  // Called just after a negedge; holds the inputs across one posedge.
  task automatic applyStimulus(input bit rst, input bit ss, input bit clr,
                               input bit lp, input bit fs);
    reset = rst; start_stop = ss; clear = clr; lap = lp; frame_start = fs;
    @(posedge clk);
    modelStep(rst, ss, clr, lp, fs);
    @(negedge clk);
    reset = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic checkField(input string tag, input string field,
                            input logic [31:0] got, input int exp);
    n_asserts++;
    assert (got === 32'(exp)) else begin
      n_fail++;
      $error("[TB] FAIL %s.%s: observed %0d expected %0d", tag, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkField(tag, "hours",   32'(hours),        m_disp / 3600000);
    checkField(tag, "minutes", 32'(minutes),      (m_disp / 60000) % 60);
    checkField(tag, "seconds", 32'(seconds),      (m_disp / 1000) % 60);
    checkField(tag, "ms",      32'(milliseconds), m_disp % 1000);
    checkField(tag, "running", 32'(running),      (m_state == 1) ? 1 : 0);
    checkField(tag, "overflow", 32'(overflow),    (m_state == 3) ? 1 : 0);
    checkField(tag, "frozen",  32'(display_frozen), m_frozen ? 1 : 0);
  endtask

  // Deposits a time into the live counters; only used while PAUSED.
  task automatic preload(input int ms_total);
    dut.u_time.presc_q = '0;
    dut.u_time.hour_q  = 4'(ms_total / 3600000);
    dut.u_time.min_q   = 6'((ms_total / 60000) % 60);
    dut.u_time.sec_q   = 6'((ms_total / 1000) % 60);
    dut.u_time.ms_q    = 10'(ms_total % 1000);
    m_total = ms_total;
    m_sub   = 0;
  endtask

  initial begin
    @(negedge clk);
    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset");

    $display("[TB] basic counting");
    applyStimulus(0, 1, 0, 0, 0);
    idle(4000);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("basic");

    $display("[TB] pause and resume");
    idle(1);
    applyStimulus(0, 1, 0, 0, 0);
    idle(100);
    checkOutput("paused");
    applyStimulus(0, 1, 0, 0, 0);
    idle(1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("resumed");
    idle(4);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("resumed_1ms");

    $display("[TB] clear priority");
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("clear_same_cycle");
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("clear_frame");

    $display("[TB] lap freeze");
    applyStimulus(0, 1, 0, 0, 0);
    idle(2000);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lap_pre");
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("lap_on");
    idle(1000);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lap_held1");
    idle(1000);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lap_held2");
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lap_off");

    $display("[TB] hour cascade");
    applyStimulus(0, 1, 0, 0, 0);
    preload(3599999);
    applyStimulus(0, 1, 0, 0, 0);
    idle(3);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("pre_carry_frame");
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("hour_carry");

    $display("[TB] full");
    applyStimulus(0, 1, 0, 0, 0);
    preload(MAX_MS);
    applyStimulus(0, 1, 0, 0, 0);
    idle(4);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("full_enter");
    applyStimulus(0, 1, 0, 0, 0);
    idle(20);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("full_ignore_ss");

    $display("[TB] reset mid-run");
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    idle(50);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("before_reset");
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_mid_run");

    $display("[TB] random phase");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'b0,
                    $urandom_range(0, 199) == 0,
                    $urandom_range(0, 499) == 0,
                    $urandom_range(0, 149) == 0,
                    $urandom_range(0, 39) == 0);
      checkOutput("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
